// File: rtl/sobel_window_filter_if.sv
// -----------------------------------------------------------------------------
// sobel_window_filter_if
//   Groups the column-triple input stream and the filtered pixel output stream
//   of sobel_window_filter.
//
//   valid_i       qualifies one column triple (data0_i bottom/newest,
//                 data1_i middle, data2_i top/oldest)
//   valid_o       pixel_o / edge_o carry a fresh result this cycle
//   pixel_o       saturated Sobel magnitude
//   edge_o        pixel_o >= THRESHOLD
//   frame_done_o  pulses with the last valid_o of a frame
//
//   slave  : filter side (consumes triples, produces results)
//   master : producer/consumer side (drives triples, observes results)
// -----------------------------------------------------------------------------
interface sobel_window_filter_if;
    logic       valid_i;
    logic [7:0] data0_i;
    logic [7:0] data1_i;
    logic [7:0] data2_i;
    logic       valid_o;
    logic [7:0] pixel_o;
    logic       edge_o;
    logic       frame_done_o;

    modport slave (
        input  valid_i,
        input  data0_i,
        input  data1_i,
        input  data2_i,
        output valid_o,
        output pixel_o,
        output edge_o,
        output frame_done_o
    );

    modport master (
        output valid_i,
        output data0_i,
        output data1_i,
        output data2_i,
        input  valid_o,
        input  pixel_o,
        input  edge_o,
        input  frame_done_o
    );
endinterface

// File: rtl/sobel_window_filter.sv
// -----------------------------------------------------------------------------
// sobel_window_filter
//   3x3 Sobel edge filter fed by a double line buffer that delivers one
//   vertical column triple per accepted beat. Three-stage, non-stalling
//   pipeline:
//     stage 1  sliding 3x3 window + column/row position tracking
//     stage 2  Gx / Gy (11-bit signed)
//     stage 3  |Gx|+|Gy|, saturate to 8 bits, threshold compare
//   A triple accepted in cycle N produces valid_o in cycle N+3. Windows whose
//   newest column is at col 0 or 1 straddle a line wrap and are suppressed.
//
// Ports
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  sobel_window_filter_if.slave (valid_i/data0_i..data2_i in,
//        valid_o/pixel_o/edge_o/frame_done_o out)
//
// Parameters
//   IMG_WIDTH   triples per line (>= 3)
//   IMG_HEIGHT  image rows (>= 3); a frame carries IMG_HEIGHT-2 lines of triples
//   THRESHOLD   edge threshold applied to the saturated magnitude
// -----------------------------------------------------------------------------
module sobel_window_filter #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter logic [7:0]  THRESHOLD  = 8'd100
) (
    input logic                  clk,
    input logic                  rst,
    sobel_window_filter_if.slave bus
);

    localparam int unsigned ColW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 3) ? $clog2(IMG_HEIGHT - 2) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 3);
    localparam logic [ColW-1:0] ColFirstValid = ColW'(2);

    // Zero-extend a pixel into the signed gradient domain.
    function automatic logic signed [10:0] ext(input logic [7:0] v);
        return signed'({3'b000, v});
    endfunction

    // -------------------------------------------------------------------------
    // Position tracking
    // -------------------------------------------------------------------------
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            col_wrap;
    logic            frame_wrap;
    logic            win_valid;

    always_comb begin
        col_wrap   = bus.valid_i && (col_q == ColLast);
        frame_wrap = col_wrap && (row_q == RowLast);
        // Only windows whose three columns belong to the same line are valid.
        win_valid  = bus.valid_i && (col_q >= ColFirstValid);
        col_d      = col_q;
        row_d      = row_q;
        if (bus.valid_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: window register, indexed [row][col], row 0 = top, col 2 = newest
    // -------------------------------------------------------------------------
    logic [7:0] win_q [3][3];
    logic       v1_q;
    logic       fd1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            v1_q  <= 1'b0;
            fd1_q <= 1'b0;
        end else begin
            if (bus.valid_i) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= bus.data2_i;
                win_q[1][2] <= bus.data1_i;
                win_q[2][2] <= bus.data0_i;
            end
            v1_q  <= win_valid;
            fd1_q <= frame_wrap;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: gradients. Each partial sum is at most 1020, so 11-bit signed
    // holds every result without overflow.
    // -------------------------------------------------------------------------
    logic signed [10:0] gx_d, gy_d;
    logic signed [10:0] gx_q, gy_q;
    logic               v2_q;
    logic               fd2_q;

    always_comb begin
        gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_q  <= '0;
            gy_q  <= '0;
            v2_q  <= 1'b0;
            fd2_q <= 1'b0;
        end else begin
            v2_q  <= v1_q;
            fd2_q <= v1_q && fd1_q;
            if (v1_q) begin
                gx_q <= gx_d;
                gy_q <= gy_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: magnitude, saturation, threshold. |-1020| still fits 11 bits
    // unsigned and the sum peaks at 2040.
    // -------------------------------------------------------------------------
    logic [10:0] abs_gx, abs_gy, mag;
    logic [7:0]  pix_d;
    logic        edge_d;
    logic [7:0]  pix_q;
    logic        edge_q;
    logic        valid_q;
    logic        fd_q;

    always_comb begin
        abs_gx = gx_q[10] ? unsigned'(-gx_q) : unsigned'(gx_q);
        abs_gy = gy_q[10] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag    = abs_gx + abs_gy;
        pix_d  = (mag > 11'd255) ? 8'hFF : mag[7:0];
        edge_d = (pix_d >= THRESHOLD);
    end

    // pixel/edge hold their last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q   <= '0;
            edge_q  <= 1'b0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            valid_q <= v2_q;
            fd_q    <= v2_q && fd2_q;
            if (v2_q) begin
                pix_q  <= pix_d;
                edge_q <= edge_d;
            end
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.pixel_o      = pix_q;
    assign bus.edge_o       = edge_q;
    assign bus.frame_done_o = fd_q;

endmodule

// File: tb/tb_sobel_window_filter.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_filter
//   Two filter instances share one input stream (THRESHOLD 100 and 40).
//   A reference model keeps the last three accepted columns and the frame
//   position as plain integers, computes each expected Sobel result directly
//   from the pixel formula, and schedules it for the cycle it must appear.
// -----------------------------------------------------------------------------
module tb_sobel_window_filter;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_window_filter_if bus_a ();
    sobel_window_filter_if bus_b ();

    sobel_window_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(8'd100)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sobel_window_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(8'd40)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        int due;
        int pix;
        int e100;
        int e40;
        int fd;
    } exp_t;

    typedef struct {
        int t;
        int m;
        int b;
    } col_t;

    exp_t q[$];
    col_t hist[$];
    int   cyc = 0;
    int   k   = 0;
    int   last_pix, last_e100, last_e40;
    int   n_valid, n_fd;
    int   obs_pix[$], obs_e100[$], obs_e40[$];
    int   ntot  = 0;
    int   nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntot++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        hist.delete();
        k         = 0;
        last_pix  = 0;
        last_e100 = 0;
        last_e40  = 0;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Accept one column into the model; schedule an output if the window
    // lies entirely within one line.
    function automatic void accept(input int d0, input int d1, input int d2);
        int   col, row, gx, gy, mag, pix;
        exp_t e;
        col_t c0, c1, c2;
        col = k % W;
        row = k / W;
        hist.push_back('{t: d2, m: d1, b: d0});
        if (hist.size() > 3) void'(hist.pop_front());
        if (col >= 2) begin
            c0  = hist[0];
            c1  = hist[1];
            c2  = hist[2];
            gx  = (c2.t + 2 * c2.m + c2.b) - (c0.t + 2 * c0.m + c0.b);
            gy  = (c0.b + 2 * c1.b + c2.b) - (c0.t + 2 * c1.t + c2.t);
            mag = iabs(gx) + iabs(gy);
            pix = (mag > 255) ? 255 : mag;
            e.due  = cyc + 2;
            e.pix  = pix;
            e.e100 = (pix >= 100) ? 1 : 0;
            e.e40  = (pix >= 40) ? 1 : 0;
            e.fd   = (col == W - 1 && row == H - 3) ? 1 : 0;
            q.push_back(e);
        end
        k = (k + 1) % (W * (H - 2));
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (bus_a.valid_o === 1'b1) begin
            n_valid++;
            obs_pix.push_back(int'(bus_a.pixel_o));
            obs_e100.push_back(int'(bus_a.edge_o));
            obs_e40.push_back(int'(bus_b.edge_o));
        end
        if (bus_a.frame_done_o === 1'b1) n_fd++;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("valid", 32'(bus_a.valid_o), 32'd1);
            chk("valid_b", 32'(bus_b.valid_o), 32'd1);
            chk("pixel", 32'(bus_a.pixel_o), 32'(e.pix));
            chk("edge_t100", 32'(bus_a.edge_o), 32'(e.e100));
            chk("edge_t40", 32'(bus_b.edge_o), 32'(e.e40));
            chk("frame_done", 32'(bus_a.frame_done_o), 32'(e.fd));
            last_pix  = e.pix;
            last_e100 = e.e100;
            last_e40  = e.e40;
        end else begin
            chk("idle_valid", 32'(bus_a.valid_o), 32'd0);
            chk("idle_valid_b", 32'(bus_b.valid_o), 32'd0);
            chk("hold_pixel", 32'(bus_a.pixel_o), 32'(last_pix));
            chk("hold_edge", 32'(bus_a.edge_o), 32'(last_e100));
            chk("idle_frame_done", 32'(bus_a.frame_done_o), 32'd0);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked at the next one.
    task automatic step(input logic v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2);
        bus_a.valid_i = v;
        bus_a.data0_i = d0;
        bus_a.data1_i = d1;
        bus_a.data2_i = d2;
        bus_b.valid_i = v;
        bus_b.data0_i = d0;
        bus_b.data1_i = d1;
        bus_b.data2_i = d2;
        @(posedge clk);
        cyc++;
        if (v && !rst) accept(int'(d0), int'(d1), int'(d2));
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic clear_obs();
        n_valid = 0;
        n_fd    = 0;
        obs_pix.delete();
        obs_e100.delete();
        obs_e40.delete();
    endtask

    function automatic logic [7:0] rpix();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus_a.valid_o), 32'd0);
        chk({tag, "_pixel"}, 32'(bus_a.pixel_o), 32'd0);
        chk({tag, "_edge"}, 32'(bus_a.edge_o), 32'd0);
        chk({tag, "_frame_done"}, 32'(bus_a.frame_done_o), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        int         acc;
        model_reset();
        clear_obs();
        bus_a.valid_i = 1'b0;
        bus_a.data0_i = '0;
        bus_a.data1_i = '0;
        bus_a.data2_i = '0;
        bus_b.valid_i = 1'b0;
        bus_b.data0_i = '0;
        bus_b.data1_i = '0;
        bus_b.data2_i = '0;

        // Reset holds outputs low before any clock edge.
        #1;
        check_reset_outputs("reset_async");
        @(negedge clk);
        idle(2);
        rst = 1'b0;

        // Flat frame: 12 zero outputs, one frame_done on the last.
        clear_obs();
        for (int i = 0; i < int'(W * (H - 2)); i++) step(1'b1, 8'd80, 8'd80, 8'd80);
        idle(4);
        chk("flat_count", 32'(n_valid), 32'd12);
        chk("flat_frame_done_count", 32'(n_fd), 32'd1);

        // Vertical step edge; also no outputs for windows across the line wrap.
        clear_obs();
        for (int i = 0; i < int'(W * (H - 2)); i++) begin
            v = ((i % W) >= 3) ? 8'd255 : 8'd0;
            step(1'b1, v, v, v);
        end
        idle(4);
        chk("vstep_count", 32'(n_valid), 32'd12);
        chk("vstep_col3_pixel", 32'(obs_pix[1]), 32'd255);
        chk("vstep_col3_edge", 32'(obs_e100[1]), 32'd1);
        chk("vstep_col5_pixel", 32'(obs_pix[3]), 32'd0);
        chk("vstep_line2_col3_pixel", 32'(obs_pix[7]), 32'd255);

        // Small gradient: 10,10,20 -> 40; edge only at the low threshold.
        clear_obs();
        for (int i = 0; i < int'(W * (H - 2)); i++) begin
            v = ((i % W) < 2) ? 8'd10 : 8'd20;
            step(1'b1, v, v, v);
        end
        idle(4);
        chk("grad_pixel", 32'(obs_pix[0]), 32'd40);
        chk("grad_edge_t100", 32'(obs_e100[0]), 32'd0);
        chk("grad_edge_t40", 32'(obs_e40[0]), 32'd1);

        // Bubbles: valid alternating 1,0 over a full random frame.
        clear_obs();
        for (int i = 0; i < int'(W * (H - 2)); i++) begin
            step(1'b1, rpix(), rpix(), rpix());
            step(1'b0, rpix(), rpix(), rpix());
        end
        idle(4);
        chk("bubble_count", 32'(n_valid), 32'd12);
        chk("bubble_frame_done_count", 32'(n_fd), 32'd1);

        // Reset with two results in flight (cols 2 and 3).
        for (int i = 0; i < 4; i++) step(1'b1, rpix(), rpix(), rpix());
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clk);
        step(1'b0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;
        clear_obs();
        idle(3);
        chk("reset_flush_count", 32'(n_valid), 32'd0);
        step(1'b1, 8'd0, 8'd0, 8'd0);
        step(1'b1, 8'd0, 8'd0, 8'd0);
        step(1'b1, 8'd200, 8'd200, 8'd200);
        idle(4);
        chk("reset_fresh_count", 32'(n_valid), 32'd1);
        chk("reset_fresh_pixel", 32'(obs_pix[0]), 32'd255);
        for (int i = 3; i < int'(W * (H - 2)); i++) step(1'b1, rpix(), rpix(), rpix());
        idle(4);

        // Two random frames with random bubbles.
        clear_obs();
        acc = 0;
        for (int i = 0; i < 400 && acc < int'(2 * W * (H - 2)); i++) begin
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, rpix(), rpix(), rpix());
                acc++;
            end else begin
                step(1'b0, rpix(), rpix(), rpix());
            end
        end
        idle(4);
        chk("random_accepted", 32'(acc), 32'(2 * W * (H - 2)));
        chk("random_count", 32'(n_valid), 32'd24);
        chk("random_frame_done_count", 32'(n_fd), 32'd2);
        chk("model_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", ntot - nfail, ntot);
        $finish;
    end

endmodule

// File: doc/sobel_window_filter.md
SOBEL_WINDOW_FILTER -- requirements
Module: sobel_window_filter

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per image row (column-triples per line), at least 3.
REQ-002 Parameter IMG_HEIGHT, default 480, rows per frame, at least 3; output rows per frame are IMG_HEIGHT-2.
REQ-003 Parameter THRESHOLD, default 100, 8-bit edge threshold compared against the saturated magnitude.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 valid_i  input  1  qualifies data0_i/data1_i/data2_i as one column triple; driven by the upstream double line buffer's done output.
REQ-007 data0_i  input  8  bottom-row (newest) pixel of the column.
REQ-008 data1_i  input  8  middle-row pixel of the column.
REQ-009 data2_i  input  8  top-row (oldest) pixel of the column.
REQ-010 valid_o  output  1  pixel_o/edge_o hold a valid result this cycle.
REQ-011 pixel_o  output  8  Sobel magnitude, saturated to 255.
REQ-012 edge_o  output  1  high when pixel_o >= THRESHOLD.
REQ-013 frame_done_o  output  1  one-cycle pulse coincident with the last valid_o of a frame.

Function
REQ-014 Window: 3x3 array p[r][c], r=0 top/1 mid/2 bottom, c=0 left/2 right; on valid_i each row shifts left (c0<=c1, c1<=c2) and c2 loads data2_i/data1_i/data0_i for r=0/1/2. With valid_i low the window holds.
REQ-015 Column counter col counts accepted triples 0..IMG_WIDTH-1 and wraps to 0 on the triple accepted at IMG_WIDTH-1; row counter row increments on that wrap.
REQ-016 A window is valid when the accepted triple has col >= 2; windows at col 0 and 1 produce no output (no horizontal wrap across lines).
REQ-017 Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20); Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02); both held as 11-bit signed, range -1020..+1020, no overflow.
REQ-018 mag = |Gx| + |Gy| as 11-bit unsigned (max 2040); pixel_o = 255 when mag > 255, else mag[7:0].
REQ-019 Pipeline: stage 1 window register, stage 2 Gx/Gy register, stage 3 abs/sum/saturate/threshold register; a valid triple accepted in cycle N yields valid_o high in cycle N+3.
REQ-020 Pipeline never stalls; a valid flag travels with each stage; bubbles (valid_i low) propagate as valid_o low, and pixel_o/edge_o hold their last values while valid_o is low.
REQ-021 Output row count: row runs 0..IMG_HEIGHT-3; frame_done_o pulses with the valid_o of the window at col=IMG_WIDTH-1, row=IMG_HEIGHT-3, after which row and col both return to 0.
REQ-022 valid_i continuously high for an entire frame is legal and yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs with no gaps other than 2 cycles per line.

Reset
REQ-023 While rst is high: valid_o=0, pixel_o=0, edge_o=0, frame_done_o=0, col=0, row=0, window and Gx/Gy registers all 0; takes effect immediately, with no clock edge required.
REQ-024 Reset asserted mid-frame discards all in-flight pipeline results; after release the next accepted triple is treated as col 0, row 0.

Verification
REQ-025 Flat frame, all pixels 80, IMG_WIDTH=8, IMG_HEIGHT=4 -> 12 outputs, each pixel_o=0 and edge_o=0; frame_done_o pulses once, on the 12th output.
REQ-026 Vertical step: columns 0-2 are 0 and columns 3+ are 255 in all rows -> window at col 3 gives Gx=1020 and pixel_o=255 (saturated), edge_o=1; window at col 5 gives pixel_o=0.
REQ-027 Small gradient: left column 10, middle 10, right 20 in every row -> Gx=40, Gy=0, pixel_o=40; edge_o=0 with THRESHOLD=100 and edge_o=1 with THRESHOLD=40.
REQ-028 Latency/bubbles: valid_i toggled 1,0,1,0 with col >= 2 -> valid_o follows exactly 3 cycles later in the same pattern, and outputs equal the no-gap reference.
REQ-029 Line boundary: accept the triples at col 7 then col 0,1 of the next line -> no valid_o for windows spanning the line wrap; the next valid_o comes from col 2.
REQ-030 Assert rst for 1 cycle while 2 results are in flight -> valid_o stays 0 for those results; a fresh line then produces its first output 3 cycles after col 2.
